// File: rtl/hazard_fwd_ctrl_if.sv
// Connection bundle between the decode stage and the hazard/forwarding controller.
// The pipeline drives the decode-side fields; the controller returns mux selects, stall/flush and counters.
interface hazard_fwd_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [RA_W-1:0] id_rd;
  logic            id_we;
  logic            id_is_load;
  logic            br_taken;

  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             flush_ex;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, br_taken,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
           load_use_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, br_taken,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
           load_use_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: shadow pipeline of destination info (EX/MEM/WB/RET),
// operand-mux selects, load-use stall, branch flush and saturating debug counters.
module hazard_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, rd: {RA_W{1'b0}}, we: 1'b0};

  stage_t           ex_q, ex_d, mem_q, wb_q, ret_q;
  logic             ex_is_load_q, ex_is_load_d;
  logic [RA_W-1:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic             ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;

  logic             lu_raw_s, br_s, lu_stall_s, flush_ex_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  function automatic logic src_match(input stage_t s, input logic [RA_W-1:0] r);
    return s.valid && s.we && (s.rd != {RA_W{1'b0}}) && (s.rd == r);
  endfunction

  // Nearest producer wins; RET covers a register file without write-first bypass.
  function automatic logic [1:0] fwd_sel(input logic live, input logic [RA_W-1:0] r,
                                         input stage_t m, input stage_t w, input stage_t t);
    logic [1:0] sel;
    sel = 2'b00;
    if (!live)                sel = 2'b00;
    else if (src_match(m, r)) sel = 2'b01;
    else if (src_match(w, r)) sel = 2'b10;
    else if (src_match(t, r)) sel = 2'b11;
    else                      sel = 2'b00;
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    logic [CNT_W-1:0] n;
    n = c;
    if (en && (c != {CNT_W{1'b1}})) n = c + {{(CNT_W-1){1'b0}}, 1'b1};
    else                            n = c;
    return n;
  endfunction

  // Hazard detection and operand selects, all combinational from shadow state and ID inputs.
  always_comb begin
    lu_raw_s = ex_q.valid && ex_is_load_q && ex_q.we && (ex_q.rd != {RA_W{1'b0}}) && bus.id_valid &&
               ((bus.id_rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == ex_q.rd)));
    br_s       = bus.br_taken && !rst;
    // A taken branch discards the ID instruction, so its load-use stall is moot.
    lu_stall_s = lu_raw_s && !br_s && !rst;
    flush_ex_s = lu_stall_s || br_s;
    fwd_a_s    = fwd_sel(ex_q.valid && ex_rs1_used_q, ex_rs1_q, mem_q, wb_q, ret_q);
    fwd_b_s    = fwd_sel(ex_q.valid && ex_rs2_used_q, ex_rs2_q, mem_q, wb_q, ret_q);
  end

  // Next EX entry: bubble when flushed, otherwise the ID instruction gated by id_valid.
  always_comb begin
    ex_d          = BUBBLE;
    ex_is_load_d  = 1'b0;
    ex_rs1_d      = {RA_W{1'b0}};
    ex_rs2_d      = {RA_W{1'b0}};
    ex_rs1_used_d = 1'b0;
    ex_rs2_used_d = 1'b0;
    if (flush_ex_s) begin
      ex_d = BUBBLE;
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.rd       = bus.id_rd;
      ex_d.we       = bus.id_we;
      ex_is_load_d  = bus.id_is_load;
      ex_rs1_d      = bus.id_rs1;
      ex_rs2_d      = bus.id_rs2;
      ex_rs1_used_d = bus.id_rs1_used;
      ex_rs2_used_d = bus.id_rs2_used;
    end
    lu_cnt_d = sat_inc(lu_cnt_q, lu_stall_s);
    fl_cnt_d = sat_inc(fl_cnt_q, br_s);
  end

  // Shadow pipeline advance and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      ret_q         <= BUBBLE;
      ex_is_load_q  <= 1'b0;
      ex_rs1_q      <= {RA_W{1'b0}};
      ex_rs2_q      <= {RA_W{1'b0}};
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      lu_cnt_q      <= {CNT_W{1'b0}};
      fl_cnt_q      <= {CNT_W{1'b0}};
    end else begin
      ret_q         <= wb_q;
      wb_q          <= mem_q;
      mem_q         <= ex_q;
      ex_q          <= ex_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
      lu_cnt_q      <= lu_cnt_d;
      fl_cnt_q      <= fl_cnt_d;
    end
  end

  assign bus.fwd_a_sel    = fwd_a_s;
  assign bus.fwd_b_sel    = fwd_b_s;
  assign bus.stall_if     = lu_stall_s;
  assign bus.stall_id     = lu_stall_s;
  assign bus.flush_id     = br_s;
  assign bus.flush_ex     = flush_ex_s;
  assign bus.load_use_cnt = lu_cnt_q;
  assign bus.flush_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_hazard_fwd_ctrl;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [CNT_W-1:0] exp_lu;
  logic [CNT_W-1:0] exp_fl;

  hazard_fwd_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  hazard_fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    bus.id_valid = v; bus.id_rs1 = r1; bus.id_rs2 = r2;
    bus.id_rs1_used = u1; bus.id_rs2_used = u2;
    bus.id_rd = rd; bus.id_we = we; bus.id_is_load = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    bus.br_taken = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    bus.br_taken = 1'b1;
    #1;
    checks++;
    if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %0h expected 0",
               {bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.br_taken = 1'b0;
    nop();
    #1;
    checks++;
    if (bus.load_use_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) begin
      failures++;
      $display("FAIL reset_cnt: got lu=%0h fl=%0h expected 0 0", bus.load_use_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_fwd_distance();
    logic [1:0] exp_sel;
    for (int opb = 0; opb < 2; opb++) begin
      for (int d = 1; d <= 4; d++) begin
        drain();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        nop();
        repeat (d - 1) @(negedge clk);
        if (opb == 0) set_id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        else          set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        @(negedge clk);
        nop();
        #1;
        case (d)
          1:       exp_sel = 2'b01;
          2:       exp_sel = 2'b10;
          3:       exp_sel = 2'b11;
          default: exp_sel = 2'b00;
        endcase
        checks++;
        if (opb == 0 && (bus.fwd_a_sel !== exp_sel || bus.fwd_b_sel !== 2'b00)) begin
          failures++;
          $display("FAIL dist_a d=%0d: got a=%0b b=%0b expected a=%0b b=00", d, bus.fwd_a_sel, bus.fwd_b_sel, exp_sel);
        end
        if (opb == 1 && (bus.fwd_b_sel !== exp_sel || bus.fwd_a_sel !== 2'b00)) begin
          failures++;
          $display("FAIL dist_b d=%0d: got a=%0b b=%0b expected a=00 b=%0b", d, bus.fwd_a_sel, bus.fwd_b_sel, exp_sel);
        end
      end
    end
  endtask

  task automatic test_x0_unused();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
      failures++;
      $display("FAIL x0_fwd: got a=%0b b=%0b expected 00 00", bus.fwd_a_sel, bus.fwd_b_sel);
    end
    @(negedge clk);
    set_id(1'b1, 5'd6, 5'd6, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b00) begin
      failures++;
      $display("FAIL unused_b: got a=%0b b=%0b expected 01 00", bus.fwd_a_sel, bus.fwd_b_sel);
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    checks++;
    if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id} !== 4'b1110) begin
      failures++;
      $display("FAIL lu_stall: got if/id/fex/fid=%b expected 1110", {bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id});
    end
    @(negedge clk);
    exp_lu = exp_lu + 4'd1;
    #1;
    checks++;
    if ({bus.stall_if, bus.stall_id, bus.flush_ex} !== 3'b000) begin
      failures++;
      $display("FAIL lu_clear: got if/id/fex=%b expected 000", {bus.stall_if, bus.stall_id, bus.flush_ex});
    end
    checks++;
    if (bus.load_use_cnt !== exp_lu) begin
      failures++;
      $display("FAIL lu_cnt: got %0h expected %0h", bus.load_use_cnt, exp_lu);
    end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (bus.fwd_a_sel !== 2'b10 || bus.fwd_b_sel !== 2'b00) begin
      failures++;
      $display("FAIL lu_fwd: got a=%0b b=%0b expected 10 00", bus.fwd_a_sel, bus.fwd_b_sel);
    end
  endtask

  task automatic test_branch_collision();
    drain();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.br_taken = 1'b1;
    #1;
    checks++;
    if ({bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id} !== 4'b1100) begin
      failures++;
      $display("FAIL br_coll: got fid/fex/sif/sid=%b expected 1100", {bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id});
    end
    @(negedge clk);
    bus.br_taken = 1'b0;
    nop();
    exp_fl = exp_fl + 4'd1;
    #1;
    checks++;
    if (bus.flush_cnt !== exp_fl || bus.load_use_cnt !== exp_lu) begin
      failures++;
      $display("FAIL br_cnt: got fl=%0h lu=%0h expected fl=%0h lu=%0h", bus.flush_cnt, bus.load_use_cnt, exp_fl, exp_lu);
    end
    checks++;
    if (bus.fwd_a_sel !== 2'b00 || bus.stall_if !== 1'b0) begin
      failures++;
      $display("FAIL br_bubble: got a=%0b stall=%0b expected 00 0", bus.fwd_a_sel, bus.stall_if);
    end
  endtask

  task automatic test_saturation();
    drain();
    bus.br_taken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_fl != 4'hF) exp_fl = exp_fl + 4'd1;
      #1;
      checks++;
      if (bus.flush_cnt !== exp_fl) begin
        failures++;
        $display("FAIL sat_step%0d: got %0h expected %0h", i, bus.flush_cnt, exp_fl);
      end
    end
    bus.br_taken = 1'b0;
    checks++;
    if (bus.flush_cnt !== 4'hF) begin
      failures++;
      $display("FAIL sat_final: got %0h expected f", bus.flush_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    drain();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.stall_if !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_stall: got %0b expected 1", bus.stall_if);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 8'h00 ||
        bus.load_use_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset: got ctrl=%0h lu=%0h fl=%0h expected 0 0 0",
               {bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex},
               bus.load_use_cnt, bus.flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_lu = 4'h0;
    exp_fl = 4'h0;
    #1;
    checks++;
    if ({bus.stall_if, bus.flush_ex, bus.fwd_a_sel, bus.fwd_b_sel} !== 6'b000000) begin
      failures++;
      $display("FAIL post_reset: got sif/fex/a/b=%b expected 000000", {bus.stall_if, bus.flush_ex, bus.fwd_a_sel, bus.fwd_b_sel});
    end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (bus.fwd_a_sel !== 2'b00 || bus.load_use_cnt !== exp_lu || bus.flush_cnt !== exp_fl) begin
      failures++;
      $display("FAIL post_reset_cnt: got a=%0b lu=%0h fl=%0h expected 00 0 0", bus.fwd_a_sel, bus.load_use_cnt, bus.flush_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_lu   = 4'h0;
    exp_fl   = 4'h0;
    test_reset();
    test_fwd_distance();
    test_x0_unused();
    test_load_use();
    test_branch_collision();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
